// File: rtl/tdm_pkg.sv
// Shared types and constants for the 32-channel TDM transmit path.
package tdm_pkg;

    localparam int NCH  = 32;
    localparam int SELW = 5;

    typedef logic [SELW-1:0] chan_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_mux_32x1_if.sv
// Parallel-in / serial-out bus of the TDM multiplexer.
// slave is the multiplexer side, master is the upstream source plus downstream sink.
interface tdm_mux_32x1_if #(
    parameter int FCW = 16
);
    import tdm_pkg::*;

    logic [NCH-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic           o;
    chan_sel_t      sel;
    logic           o_valid;
    logic           o_ready;
    logic           frame_start;
    logic           frame_end;
    logic [FCW-1:0] frame_cnt;

    modport slave (
        input  in_data, in_valid, o_ready,
        output in_ready, o, sel, o_valid, frame_start, frame_end, frame_cnt
    );

    modport master (
        output in_data, in_valid, o_ready,
        input  in_ready, o, sel, o_valid, frame_start, frame_end, frame_cnt
    );

endinterface

// File: rtl/tdm_frame_counter.sv
// Wrapping count of completed frames, used for link bring-up and debug.
module tdm_frame_counter #(
    parameter int FCW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    output logic [FCW-1:0] cnt
);

    // Count one per completed frame; wraps naturally at 2**FCW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_mux_32x1.sv
// 32-to-1 time-division multiplexer: accepts a parallel word and presents
// it one channel per output beat as (o, sel), bit 0 first. A new word can be
// loaded on the last beat of a frame, so full-rate traffic has no bubbles.
module tdm_mux_32x1
    import tdm_pkg::*;
#(
    parameter int FCW = 16
) (
    input  logic          clk,
    input  logic          rst,
    tdm_mux_32x1_if.slave bus
);

    localparam chan_sel_t LAST_SEL = chan_sel_t'(NCH - 1);

    tdm_state_t     state;
    logic [NCH-1:0] shreg;
    logic           o_bit;
    chan_sel_t      sel_q;
    logic           o_valid_q;
    logic           frame_start_q;
    logic           frame_end_q;
    logic [FCW-1:0] frame_cnt;

    logic           in_ready;
    logic           accept;
    logic           beat;
    logic           frame_done;
    chan_sel_t      sel_inc;

    // Ready while idle, or on the final beat of a frame that is being consumed,
    // which lets the next word follow without a gap.
    assign in_ready   = (state == IDLE) || (bus.o_ready && (sel_q == LAST_SEL));
    assign accept     = bus.in_valid && in_ready;
    assign beat       = o_valid_q && bus.o_ready;
    assign frame_done = beat && (sel_q == LAST_SEL);
    assign sel_inc    = sel_q + 1'b1;

    // Frame sequencer: load, shift one channel per beat, hold on stall.
    // shreg always holds the channels not yet presented, next one in bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            o_bit         <= 1'b0;
            sel_q         <= '0;
            o_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= SEND;
                        shreg         <= {1'b0, bus.in_data[NCH-1:1]};
                        o_bit         <= bus.in_data[0];
                        sel_q         <= '0;
                        o_valid_q     <= 1'b1;
                        frame_start_q <= 1'b1;
                        frame_end_q   <= 1'b0;
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (sel_q != LAST_SEL) begin
                            shreg         <= {1'b0, shreg[NCH-1:1]};
                            o_bit         <= shreg[0];
                            sel_q         <= sel_inc;
                            frame_start_q <= 1'b0;
                            frame_end_q   <= (sel_inc == LAST_SEL);
                        end else if (accept) begin
                            shreg         <= {1'b0, bus.in_data[NCH-1:1]};
                            o_bit         <= bus.in_data[0];
                            sel_q         <= '0;
                            frame_start_q <= 1'b1;
                            frame_end_q   <= 1'b0;
                        end else begin
                            state         <= IDLE;
                            shreg         <= '0;
                            o_bit         <= 1'b0;
                            sel_q         <= '0;
                            o_valid_q     <= 1'b0;
                            frame_start_q <= 1'b0;
                            frame_end_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    tdm_frame_counter #(
        .FCW (FCW)
    ) u_frame_counter (
        .clk (clk),
        .rst (rst),
        .inc (frame_done),
        .cnt (frame_cnt)
    );

    assign bus.in_ready    = in_ready;
    assign bus.o           = o_bit;
    assign bus.sel         = sel_q;
    assign bus.o_valid     = o_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_tdm_mux_32x1.sv
// Bench for tdm_mux_32x1: table of words plus random traffic checked against
// a queue-of-expected-beats model, mid-frame reset and frame counter wrap.
module tb_tdm_mux_32x1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    tdm_mux_32x1_if #(.FCW(16)) bus ();
    tdm_mux_32x1_if #(.FCW(4))  wbus ();

    tdm_mux_32x1 #(.FCW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow-counter instance so the counter wrap is reachable in a short run.
    tdm_mux_32x1 #(.FCW(4)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    typedef struct packed {
        logic       o;
        logic [4:0] sel;
        logic       fs;
        logic       fe;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        int          stall_pct;
        logic [31:0] exp_stream;
        logic [15:0] exp_cnt;
    } vec_t;

    // Model: every accepted word becomes 32 queued beats, presented front first.
    beat_t       mq[$];
    logic [15:0] mcnt;

    int          n_vec = 0;
    int          n_err = 0;

    logic        s_ov;
    logic        s_ir;
    logic        last_acc;
    logic [31:0] rx;
    logic [31:0] rx_word;
    logic        rx_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: cycle budget expired at %0t", name, $time);
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance both.
    task automatic cycle();
        beat_t       f;
        logic        m_ir;
        logic        m_acc;
        logic        m_beat;
        logic [31:0] m_data;
        logic [9:0]  exp_b;
        logic [9:0]  act_b;
        #1;
        m_ir = (mq.size() == 0) || (bus.o_ready && mq.size() == 1);
        if (mq.size() == 0) f = '0;
        else                f = mq[0];
        exp_b = {m_ir, (mq.size() != 0), f.o, f.sel, f.fs, f.fe};
        act_b = {bus.in_ready, bus.o_valid, bus.o, bus.sel, bus.frame_start, bus.frame_end};
        chk("beat{ir,ov,o,sel,fs,fe}", {22'd0, act_b}, {22'd0, exp_b});
        chk("frame_cnt", {16'd0, bus.frame_cnt}, {16'd0, mcnt});
        s_ov = bus.o_valid;
        s_ir = bus.in_ready;
        if (bus.o_valid && bus.o_ready) begin
            rx[bus.sel] = bus.o;
            if (bus.sel == 5'd31) begin
                rx_word = rx;
                rx_done = 1'b1;
            end
        end
        m_acc  = bus.in_valid && m_ir;
        m_beat = (mq.size() != 0) && bus.o_ready;
        m_data = bus.in_data;
        @(posedge clk);
        if (m_beat) begin
            f = mq.pop_front();
            if (f.sel == 5'd31) mcnt++;
        end
        if (m_acc) begin
            for (int k = 0; k < 32; k++) begin
                mq.push_back('{o: m_data[k], sel: 5'(k), fs: (k == 0), fe: (k == 31)});
            end
        end
        last_acc = m_acc;
        #1;
    endtask

    // Offer one word, then drain it with o_ready low stall_pct percent of the time.
    task automatic send_word(input logic [31:0] data, input int stall_pct);
        logic accepted;
        logic done;
        accepted = 1'b0;
        done     = 1'b0;
        rx_done  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        for (int c = 0; c < 3000 && !done; c++) begin
            bus.o_ready = ($urandom_range(99) >= stall_pct);
            cycle();
            if (last_acc) begin
                accepted     = 1'b1;
                bus.in_valid = 1'b0;
            end
            if (accepted) bus.in_data = $urandom;
            if (accepted && mq.size() == 0) done = 1'b1;
        end
        if (!done) timeout_fail("send_word");
        chk("frame_seen", {31'd0, rx_done}, 32'd1);
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{32'hA5A5_0F01, 0,  32'hA5A5_0F01, 16'd1};
        tbl[1] = '{32'h1234_5678, 30, 32'h1234_5678, 16'd2};
        tbl[2] = '{32'hDEAD_BEEF, 50, 32'hDEAD_BEEF, 16'd3};
        tbl[3] = '{32'h8000_0001, 10, 32'h8000_0001, 16'd4};

        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.o_ready  = 1'b0;
        wbus.in_data  = '0;
        wbus.in_valid = 1'b0;
        wbus.o_ready  = 1'b0;
        mcnt = '0;
        rx = '0;
        rx_word = '0;
        rx_done = 1'b0;
        last_acc = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_o", {31'd0, bus.o}, 32'd0);
        chk("rst_sel", {27'd0, bus.sel}, 32'd0);
        chk("rst_frame_flags", {30'd0, bus.frame_start, bus.frame_end}, 32'd0);
        chk("rst_frame_cnt", {16'd0, bus.frame_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table of single words with various stall rates
        for (int i = 0; i < 4; i++) begin
            send_word(tbl[i].data, tbl[i].stall_pct);
            chk("loopback_word", rx_word, tbl[i].exp_stream);
            chk("frame_cnt_after_word", {16'd0, bus.frame_cnt}, {16'd0, tbl[i].exp_cnt});
        end

        // Back-to-back words at full rate: 64 beats, no gap
        begin
            int  nacc;
            int  nvalid;
            int  ngap;
            int  nready_busy;
            logic seen;
            logic done;
            nacc = 0; nvalid = 0; ngap = 0; nready_busy = 0;
            seen = 1'b0; done = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hFFFF_FFFF;
            bus.o_ready  = 1'b1;
            for (int c = 0; c < 200 && !done; c++) begin
                cycle();
                if (s_ov) begin
                    nvalid++;
                    seen = 1'b1;
                    if (s_ir) nready_busy++;
                end else if (seen) begin
                    ngap++;
                end
                if (last_acc) begin
                    nacc++;
                    if (nacc == 1) bus.in_data  = 32'h0000_0000;
                    if (nacc == 2) bus.in_valid = 1'b0;
                end
                if (nacc == 2 && mq.size() == 0) done = 1'b1;
            end
            if (!done) timeout_fail("back_to_back");
            chk("b2b_valid_beats", nvalid, 64);
            chk("b2b_gaps", ngap, 0);
            chk("b2b_ready_while_busy", nready_busy, 2);
            chk("b2b_frame_cnt", {16'd0, bus.frame_cnt}, 32'd6);
        end

        // Random traffic with stalls and random input gaps
        bus.in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (last_acc || !bus.in_valid) begin
                bus.in_valid = ($urandom_range(99) < 60);
                bus.in_data  = $urandom;
            end
            bus.o_ready = ($urandom_range(99) >= 30);
            cycle();
        end
        bus.in_valid = 1'b0;
        bus.o_ready  = 1'b1;
        for (int c = 0; c < 40 && mq.size() != 0; c++) cycle();
        if (mq.size() != 0) timeout_fail("random_drain");

        // Reset in the middle of a frame at sel = 17
        begin
            logic hit;
            hit = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hC3C3_3C3C;
            bus.o_ready  = 1'b1;
            for (int c = 0; c < 100 && !hit; c++) begin
                cycle();
                if (last_acc) bus.in_valid = 1'b0;
                if (mq.size() != 0 && mq[0].sel == 5'd17) hit = 1'b1;
            end
            if (!hit) timeout_fail("reach_sel17");
            chk("pre_rst_frame_cnt_nonzero", {31'd0, (bus.frame_cnt != 16'd0)}, 32'd1);
            #2 rst = 1'b1;
            #1;
            chk("async_rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
            chk("async_rst_sel", {27'd0, bus.sel}, 32'd0);
            chk("async_rst_o", {31'd0, bus.o}, 32'd0);
            chk("async_rst_frame_cnt", {16'd0, bus.frame_cnt}, 32'd0);
            chk("async_rst_flags", {30'd0, bus.frame_start, bus.frame_end}, 32'd0);
            @(posedge clk);
            #1 rst = 1'b0;
            mq.delete();
            mcnt = '0;
            send_word(32'h0F0F_00FF, 0);
            chk("post_rst_word", rx_word, 32'h0F0F_00FF);
            chk("post_rst_frame_cnt", {16'd0, bus.frame_cnt}, 32'd1);
        end

        // Frame counter wrap on the 4-bit instance: frame f completes at edge 1+32f
        wbus.in_valid = 1'b1;
        wbus.o_ready  = 1'b1;
        wbus.in_data  = $urandom;
        for (int e = 1; e <= 513; e++) begin
            @(posedge clk);
            #1;
            wbus.in_data = $urandom;
            if (e == 480) chk("wrap_cnt_e480", {28'd0, wbus.frame_cnt}, 32'd14);
            if (e == 481) chk("wrap_cnt_e481", {28'd0, wbus.frame_cnt}, 32'd15);
            if (e == 512) chk("wrap_cnt_e512", {28'd0, wbus.frame_cnt}, 32'd15);
            if (e == 513) chk("wrap_cnt_e513", {28'd0, wbus.frame_cnt}, 32'd0);
        end
        wbus.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/tdm_mux_32x1.md
Name: tdm_mux_32x1

Overview:
- Transmit-side counterpart of the 1-to-32 demultiplexer. Accepts a 32-bit parallel word over a valid/ready handshake.
- Time-division multiplexes the word onto a single serial bit. Presents one channel per accepted output beat, with the matching 5-bit channel select, so the pair (o, sel) drives the demultiplexer's (i, sel) directly.
- Provides frame delimiters and a frame counter for link bring-up and debug.

Parameters:
- NCH, 32, number of channels per frame. Fixed at 32 for this block; must equal 2**SELW.
- SELW, 5, select width.
- FCW, 16, frame counter width.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  32  parallel word; bit k is channel k.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- o  output  1  serial channel bit (registered).
- sel  output  SELW  channel index of o (registered).
- o_valid  output  1  o/sel are valid.
- o_ready  input  1  downstream consumes the beat this cycle.
- frame_start  output  1  high while the beat with sel=0 is presented.
- frame_end  output  1  high while the beat with sel=31 is presented.
- frame_cnt  output  FCW  number of completed frames, modulo 2**FCW.

Behaviour:
- Reset (async assert, sync release to first clk edge) forces:
  - shift register = 0, o = 0, sel = 0, o_valid = 0;
  - frame_start = 0, frame_end = 0, frame_cnt = 0;
  - state = IDLE.
- States:
  - IDLE: o_valid = 0.
  - SEND: o_valid = 1.
- Handshakes:
  - Input accept = in_valid && in_ready.
  - Output beat = o_valid && o_ready.
- in_ready is combinational: in_ready = (state==IDLE) || (o_ready && sel==31). in_ready does not depend on in_valid.
- IDLE -> SEND on input accept:
  - capture in_data;
  - next cycle: o = in_data[0], sel = 0, o_valid = 1, frame_start = 1.
  - Latency from accept to first beat is 1 cycle.
- SEND on an output beat with sel < 31:
  - sel <= sel+1;
  - o <= captured bit[sel+1];
  - frame_start <= 0;
  - frame_end <= (sel+1 == 31).
- SEND with o_ready = 0 (stall): o, sel, o_valid, frame_start and frame_end hold unchanged. This holds for any number of cycles.
- SEND on an output beat with sel == 31 (frame complete):
  - frame_cnt increments, wrapping from 2**FCW-1 to 0.
  - If input accept occurs in the same cycle: load the new word, sel <= 0, o <= new bit0, frame_start <= 1, frame_end <= 0, stay in SEND. No bubble, so 32 cycles per word at full rate.
  - Otherwise: go to IDLE; o_valid <= 0, o <= 0, sel <= 0, frame flags <= 0.
- in_data changes while in SEND have no effect except when loaded at the frame boundary.
- Reset asserted mid-frame aborts the frame:
  - outputs return to reset values immediately, without waiting for the clock;
  - the partial frame is not counted and not resumed.
- sel always wraps within 0..31; no other select values are produced.

Decomposition:
- Shared package tdm_pkg:
  - constants NCH = 32, SELW = 5;
  - typedef chan_sel_t = logic [SELW-1:0];
  - enum tdm_state_t {IDLE, SEND}.
- One natural sub-module: tdm_frame_counter. It is an FCW-bit wrapping counter with increment enable and async active-high reset. Everything else stays in tdm_mux_32x1.

Test Plan:
- Reset then single word 32'hA5A5_0F01, o_ready = 1 constantly:
  - o_valid rises 1 cycle after accept;
  - sel goes 0..31 on consecutive cycles;
  - o sequence is 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0, then 1,0,1,0,0,1,0,1 twice;
  - frame_start only at sel=0, frame_end only at sel=31;
  - then IDLE, frame_cnt = 1.
- Back-to-back words 32'hFFFF_FFFF then 32'h0000_0000, in_valid held high:
  - exactly 64 consecutive beats with o_valid = 1, no gap;
  - in_ready high only in the sel=31 cycle;
  - frame_cnt = 2.
- Random o_ready stalls (about 30% low) on 32'h1234_5678:
  - o and sel hold during stalls;
  - a loopback through the 1x32 demux reconstructs 32'h1234_5678 after 32 beats.
- Reset asserted while sel = 17:
  - o_valid, sel, o and frame_cnt go to 0 asynchronously;
  - after release, the next word starts at sel=0.
- frame_cnt preloaded by running 65535 frames, then one more:
  - frame_cnt wraps to 0.
